// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers
// Operands are latched as magnitudes; signs are reapplied in FIX, so every op is 33 cycles.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t      state, state_next;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] opnd;
  logic        is_div;
  logic        neg_x;
  logic        neg_r;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift, div_diff;
  logic        div_ge;
  logic [63:0] div_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign Busy  = (state != S_IDLE);
  assign a_neg = !Op[0] && A[31];
  assign b_neg = !Op[0] && B[31];
  assign a_mag = a_neg ? (32'd0 - A) : A;
  assign b_mag = b_neg ? (32'd0 - B) : B;

  // acc holds {upper, multiplier} for multiply and {remainder, dividend/quotient} for divide
  assign mul_sum  = {1'b0, acc[63:32]} + {1'b0, opnd};
  assign mul_next = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:1]};

  assign div_shift = acc[63:31];
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_next  = {(div_ge ? div_diff[31:0] : div_shift[31:0]), acc[30:0], div_ge};

  assign prod_fix = neg_x ? (64'd0 - acc) : acc;
  assign quo_fix  = neg_x ? (32'd0 - acc[31:0]) : acc[31:0];
  assign rem_fix  = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (Start && !Op[2]) state_next = S_CALC;
      S_CALC:  if (cnt == 5'd31) state_next = S_FIX;
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 5'd0;
      acc    <= 64'd0;
      opnd   <= 32'd0;
      is_div <= 1'b0;
      neg_x  <= 1'b0;
      neg_r  <= 1'b0;
      HI     <= 32'd0;
      LO     <= 32'd0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (Start) begin
            if (!Op[2]) begin
              cnt    <= 5'd0;
              is_div <= Op[1];
              // a zero divisor keeps the all-ones quotient unsigned
              neg_x  <= (a_neg ^ b_neg) && !(Op[1] && (B == 32'd0));
              neg_r  <= a_neg;
              if (Op[1]) begin
                acc  <= {32'd0, a_mag};
                opnd <= b_mag;
              end else begin
                acc  <= {32'd0, b_mag};
                opnd <= a_mag;
              end
            end else if (Op == 3'b100) begin
              HI <= A;
            end else if (Op == 3'b101) begin
              LO <= A;
            end
          end
        end
        S_CALC: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + 5'd1;
        end
        S_FIX: begin
          if (is_div) begin
            HI <= rem_fix;
            LO <= quo_fix;
          end else begin
            HI <= prod_fix[63:32];
            LO <= prod_fix[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
